// File: rtl/detector_job_arbiter.sv
// detector_job_arbiter
// Shares one serial pattern detector among N requesters. A round-robin pick
// selects a job. The arbiter then clears the detector and shifts the job word
// in LSB-first. It counts the cycles where the detector reports a hit and
// returns that count to the consumer through a valid/ready response.
module detector_job_arbiter #(
  parameter  int N   = 4,
  parameter  int W   = 8,
  localparam int IDW = $clog2(N),
  localparam int HW  = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     ack,
  output logic             det_clr,
  output logic             det_in,
  input  logic             det_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [IDW-1:0]   rsp_id,
  output logic [HW-1:0]    rsp_hits,
  output logic             busy
);

  // Bit-counter width. It never collapses to zero, even when W is 1.
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [IDW-1:0]   rr_ptr_reg;
  logic [IDW-1:0]   id_reg;
  logic [W-1:0]     word_reg;
  logic [CW-1:0]    cnt_reg;
  logic [HW-1:0]    hits_reg;
  logic             det_clr_reg;
  logic             det_in_reg;
  logic             rsp_valid_reg;

  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic             grant_found;
  logic [IDW-1:0]   grant_id;
  logic [IDW:0]     grant_sum;
  logic [W-1:0]     grant_word;

  // Rotate the requests so that bit 0 is the requester at rr_ptr.
  // The first set bit of req_rot is then the round-robin winner.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[rr_ptr_reg +: N];

  // Pick the first pending requester at or after rr_ptr, wrapping modulo N.
  // Also select that requester's word so it can be latched on grant.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_sum   = '0;
    grant_word  = '0;
    for (int k = 0; k < N; k++) begin
      if (!grant_found && req_rot[k]) begin
        grant_found = 1'b1;
        grant_sum   = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
        if (grant_sum >= (IDW+1)'(N)) begin
          grant_sum = grant_sum - (IDW+1)'(N);
        end
        grant_id = grant_sum[IDW-1:0];
      end
    end
    for (int j = 0; j < N; j++) begin
      if (grant_found && grant_id == IDW'(j)) begin
        grant_word = req_data[j*W +: W];
      end
    end
  end

  // Job sequencer: grant, clear the detector, shift the word, drain the last
  // detector sample, then hold the response until the consumer takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      word_reg      <= '0;
      cnt_reg       <= '0;
      hits_reg      <= '0;
      det_clr_reg   <= 1'b0;
      det_in_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (grant_found) begin
            id_reg      <= grant_id;
            word_reg    <= grant_word;
            hits_reg    <= '0;
            det_clr_reg <= 1'b1;
            state_reg   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          det_clr_reg <= 1'b0;
          cnt_reg     <= '0;
          det_in_reg  <= word_reg[0];
          state_reg   <= S_SHIFT;
        end
        S_SHIFT: begin
          // The detector output lags det_in by one cycle.
          // Sampling starts on the second shift cycle for that reason.
          if (cnt_reg != '0) begin
            hits_reg <= hits_reg + HW'(det_out);
          end
          if (cnt_reg == CW'(W - 1)) begin
            det_in_reg <= 1'b0;
            state_reg  <= S_DRAIN;
          end else begin
            cnt_reg    <= cnt_reg + 1'b1;
            det_in_reg <= word_reg[cnt_reg + 1'b1];
          end
        end
        S_DRAIN: begin
          hits_reg      <= hits_reg + HW'(det_out);
          rsp_valid_reg <= 1'b1;
          state_reg     <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            rr_ptr_reg    <= (id_reg == IDW'(N - 1)) ? '0 : id_reg + 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // The retire pulse coincides with the response handshake cycle.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ack
      assign ack[gi] = (state_reg == S_DONE) && rsp_ready && (id_reg == IDW'(gi));
    end
  endgenerate

  assign det_clr   = det_clr_reg;
  assign det_in    = det_in_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_id    = id_reg;
  assign rsp_hits  = hits_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_detector_job_arbiter.sv
// Testbench for detector_job_arbiter.
// The bench models the shared detector: its output is 1 iff the last input bit
// was 1, and det_clr clears it. Expected results come from the job rules:
// hits equal the popcount of the word, and grants follow a round-robin scan.
module tb_detector_job_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     ack;
  logic             det_clr;
  logic             det_in;
  logic             det_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [HW-1:0]    rsp_hits;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;
  int ptr_m = 0;

  detector_job_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .det_clr   (det_clr),
    .det_in    (det_in),
    .det_out   (det_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_hits  (rsp_hits),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Detector model: remembers the previous input bit; det_clr clears it.
  logic det_q;
  always @(posedge clk) begin
    if (reset || det_clr) det_q <= 1'b0;
    else                  det_q <= det_in;
  end
  assign det_out = det_q;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [W-1:0] w);
    int c = 0;
    for (int i = 0; i < W; i++) c += int'(w[i]);
    return c;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_word(input int i, input logic [W-1:0] v);
    req_data[i*W +: W] = v;
  endtask

  task automatic randomize_words();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = W'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
  endtask

  // One job, entered at a negedge while the DUT is idle. Optional stall
  // cycles with rsp_ready low, optional mid-job req drop and data scramble.
  task automatic do_job(input logic [N-1:0] mask, input int stall,
                        input bit drop, input bit scramble);
    int eid, lat, clr_cnt, clr_at;
    logic [W-1:0] eword, din_vec;
    req = mask;
    eid = rr_pick(mask, ptr_m);
    eword = req_data[eid*W +: W];
    lat = -1; clr_cnt = 0; clr_at = -1; din_vec = '0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (scramble && c == 1) randomize_words();
      if (drop && c == 3) req[eid] = 1'b0;
      if (det_clr === 1'b1) begin clr_cnt++; clr_at = c; end
      if (c >= 2 && c <= W + 1) din_vec[c-2] = det_in;
      if (c == W + 2) chk("drain_det_in", 32'(det_in), 0);
      if (rsp_valid === 1'b1) lat = c;
    end
    chk("latency", lat, W + 3);
    chk("det_clr_count", clr_cnt, 1);
    chk("det_clr_cycle", clr_at, 1);
    chk("det_in_bits", 32'(din_vec), 32'(eword));
    chk("rsp_id", 32'(rsp_id), eid);
    chk("rsp_hits", 32'(rsp_hits), popc(eword));
    chk("ack_before_ready", 32'(ack), 0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_id", 32'(rsp_id), eid);
      chk("stall_hits", 32'(rsp_hits), popc(eword));
      chk("stall_ack", 32'(ack), 0);
      chk("stall_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    #1;
    chk("ack_onehot", 32'(ack), 32'(1) << eid);
    @(negedge clk);
    rsp_ready = 1'b0;
    req[eid] = 1'b0;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_ack", 32'(ack), 0);
    chk("post_busy", 32'(busy), 0);
    ptr_m = (eid + 1) % N;
    $display("job mask=%b id=%0d word=%h hits=%0d stall=%0d", mask, eid, eword, popc(eword), stall);
  endtask

  initial begin
    int nacks, last_c, aid, eid;
    req = '0; req_data = '0; rsp_ready = 1'b0; reset = 1'b1;

    // Reset state
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_det_clr", 32'(det_clr), 0);
    chk("rst_det_in", 32'(det_in), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_hits", 32'(rsp_hits), 0);

    // Directed: single job B1, plus the edge-case words 00, FF and 80
    set_word(0, 8'hB1); do_job(4'b0001, 0, 0, 0);
    set_word(1, 8'h00); do_job(4'b0010, 0, 0, 0);
    set_word(2, 8'hFF); do_job(4'b0100, 0, 0, 0);
    set_word(3, 8'h80); do_job(4'b1000, 0, 0, 0);

    // Round-robin pointer cases: after id 3 pick 2; after id 1 pick 3
    set_word(2, 8'h5A); do_job(4'b0100, 0, 0, 0);
    set_word(1, 8'h3C); do_job(4'b0010, 0, 0, 0);
    set_word(3, 8'hC3); do_job(4'b1010, 0, 0, 0);

    // Consumer stall with another requester pending
    randomize_words(); do_job(4'b0011, 5, 0, 0);

    // Reset during the third SHIFT cycle, after rr_ptr has moved
    randomize_words(); do_job(4'b0010, 0, 0, 0);
    req = 4'b1000;
    for (int c = 1; c <= 4; c++) @(negedge clk);
    reset = 1'b1; req = '0;
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    for (int c = 0; c < 3; c++) begin
      chk("abort_busy", 32'(busy), 0);
      chk("abort_valid", 32'(rsp_valid), 0);
      chk("abort_ack", 32'(ack), 0);
      chk("abort_det_in", 32'(det_in), 0);
      @(negedge clk);
    end
    randomize_words(); do_job(4'b1111, 0, 0, 0);

    // Throughput with all requests held and rsp_ready tied high
    do_reset();
    randomize_words();
    req = '1; rsp_ready = 1'b1;
    nacks = 0; last_c = 0;
    for (int c = 1; c <= 5 * (W + 4) + 20 && nacks < 5; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        aid = 0;
        for (int i = 0; i < N; i++) if (ack[i]) aid = i;
        eid = rr_pick('1, ptr_m);
        chk("tp_onehot", 32'($onehot(ack)), 1);
        chk("tp_id", aid, eid);
        chk("tp_hits", 32'(rsp_hits), popc(req_data[eid*W +: W]));
        if (nacks == 0) chk("tp_first", c, W + 3);
        else            chk("tp_gap", c - last_c, W + 4);
        $display("tp ack id=%0d cycle=%0d", aid, c);
        ptr_m = (eid + 1) % N;
        last_c = c;
        nacks++;
        if (nacks == 5) req = '0;
      end
    end
    chk("tp_count", nacks, 5);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("tp_idle", 32'(busy), 0);

    // Randomized jobs: random masks, stalls, mid-job drops and data scrambles
    for (int t = 0; t < 24; t++) begin
      randomize_words();
      do_job(N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
